seq_ram_player: RTL and testbench

//  - Parametrised record/playback note sequencer; successor to the fixed 30x8 RAM control/datapath pair.
//  - Records a stream of note words into on-chip RAM, then plays them back one word per step tick.
//  - Optional looped playback. Sits between the keyboard/note capture logic and the audio tone generator.

---
 rtl/seq_ram_player.sv | 167 ++++++++++++++++
 tb/tb_seq_ram_player.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_ram_player.sv
// Record/playback note sequencer: captures note words into an inferred RAM and replays them one per tick.
// Optional looped playback is compiled in with `define SEQ_RAM_LOOP_EN.
module seq_ram_player #(
  parameter int DW    = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rec_start,
  input  logic          rec_valid,
  input  logic [DW-1:0] rec_data,
  input  logic          rec_stop,
  input  logic          play_start,
  input  logic          play_stop,
  input  logic          tick,
  input  logic          loop,
  output logic [DW-1:0] note_out,
  output logic          note_valid,
  output logic [LW-1:0] length,
  output logic          busy,
  output logic          full,
  output logic          overflow,
  output logic          play_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   length_q, length_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            overflow_q, overflow_d;
  logic            loop_q, loop_d;
  logic            note_valid_q, note_valid_d;
  logic            play_done_q, play_done_d;
  logic            note_seen_q, note_seen_d;
  logic            wr_en, rd_en;
  logic            last_slot;
  logic            loop_req;

  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_data_q;

`ifdef SEQ_RAM_LOOP_EN
  assign loop_req = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_req    = 1'b0;
`endif

  assign full      = (length_q == LW'(DEPTH));
  assign busy      = (state_q != S_IDLE);
  assign length    = length_q;
  assign overflow  = overflow_q;
  assign note_valid = note_valid_q;
  assign play_done = play_done_q;
  // The RAM output register has no reset; note_out reads as zero until a note has been played.
  assign note_out  = note_seen_q ? rd_data_q : '0;

  // Wrap is decided against the recorded length, never against DEPTH.
  assign last_slot = ((LW'(rd_ptr_q) + LW'(1)) == length_q);

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    loop_d       = loop_q;
    note_valid_d = 1'b0;
    play_done_d  = 1'b0;
    note_seen_d  = note_seen_q;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rec_start) begin
          state_d    = S_RECORD;
          length_d   = '0;
          overflow_d = 1'b0;
        end else if (play_start) begin
          if (length_q == '0) begin
            play_done_d = 1'b1;
          end else begin
            state_d  = S_PLAY;
            rd_ptr_d = '0;
            loop_d   = loop_req;
          end
        end
      end
      S_RECORD: begin
        if (rec_valid) begin
          if (!full) begin
            wr_en    = 1'b1;
            length_d = length_q + LW'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (rec_stop) begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        // A stop in the same cycle as a tick suppresses the read.
        if (play_stop) begin
          state_d     = S_IDLE;
          play_done_d = 1'b1;
        end else if (tick) begin
          rd_en        = 1'b1;
          note_valid_d = 1'b1;
          note_seen_d  = 1'b1;
          if (last_slot) begin
            rd_ptr_d = '0;
            if (!loop_q) begin
              state_d     = S_IDLE;
              play_done_d = 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      length_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      loop_q       <= 1'b0;
      note_valid_q <= 1'b0;
      play_done_q  <= 1'b0;
      note_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      loop_q       <= loop_d;
      note_valid_q <= note_valid_d;
      play_done_q  <= play_done_d;
      note_seen_q  <= note_seen_d;
    end
  end

  // Reset-free so the array and its read register map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[length_q[AW-1:0]] <= rec_data;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_seq_ram_player.sv
// Directed self-checking bench for seq_ram_player (DEPTH=32, DW=8).
// Looping checks follow SEQ_RAM_LOOP_EN; without it the loop input must be ignored.
module tb_seq_ram_player;

  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          resetn;
  logic          rec_start, rec_valid, rec_stop;
  logic [DW-1:0] rec_data;
  logic          play_start, play_stop, tick, loop;
  logic [DW-1:0] note_out;
  logic          note_valid;
  logic [LW-1:0] length;
  logic          busy, full, overflow, play_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] rec_q[$];
  logic [DW-1:0] held;

  seq_ram_player #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .rec_start(rec_start), .rec_valid(rec_valid), .rec_data(rec_data), .rec_stop(rec_stop),
    .play_start(play_start), .play_stop(play_stop), .tick(tick), .loop(loop),
    .note_out(note_out), .note_valid(note_valid), .length(length),
    .busy(busy), .full(full), .overflow(overflow), .play_done(play_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Records rec_q; optionally raises rec_stop together with the last word.
  task automatic record_seq(input bit stop_with_last);
    rec_start = 1'b1;
    cyc();
    rec_start = 1'b0;
    chk("rec_busy", 32'(busy), 32'd1);
    chk("rec_ovf_clear", 32'(overflow), 32'd0);
    chk("rec_len_clear", 32'(length), 32'd0);
    for (int k = 0; k < rec_q.size(); k++) begin
      rec_valid = 1'b1;
      rec_data  = rec_q[k];
      if (stop_with_last && k == rec_q.size() - 1) rec_stop = 1'b1;
      cyc();
    end
    rec_valid = 1'b0;
    if (!stop_with_last || rec_q.size() == 0) begin
      rec_stop = 1'b1;
      cyc();
    end
    rec_stop = 1'b0;
    chk("rec_idle", 32'(busy), 32'd0);
    $display("record: %0d words offered, length=%0d full=%0d overflow=%0d",
             rec_q.size(), length, full, overflow);
  endtask

  // Issues n_ticks ticks after playback has started; expects rec_q[i % plen].
  task automatic play_check(input int n_ticks, input int plen, input bit looped, input bit gap);
    bit last;
    for (int i = 0; i < n_ticks; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      last = !looped && (i == plen - 1);
      chk($sformatf("nv_%0d", i), 32'(note_valid), 32'd1);
      chk($sformatf("note_%0d", i), 32'(note_out), 32'(rec_q[i % plen]));
      chk($sformatf("done_%0d", i), 32'(play_done), 32'(last));
      chk($sformatf("busy_%0d", i), 32'(busy), 32'(!last));
      $display("tick %0d: note=0x%02h done=%0d", i, note_out, play_done);
      if (gap) begin
        cyc();
        chk($sformatf("gap_nv_%0d", i), 32'(note_valid), 32'd0);
        chk($sformatf("gap_hold_%0d", i), 32'(note_out), 32'(rec_q[i % plen]));
      end
    end
  endtask

  task automatic start_play(input logic loop_val);
    loop       = loop_val;
    play_start = 1'b1;
    cyc();
    play_start = 1'b0;
    loop       = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; rec_start = 0; rec_valid = 0; rec_stop = 0; rec_data = '0;
    play_start = 0; play_stop = 0; tick = 0; loop = 0;
    cyc(); cyc();
    chk("rst_note", 32'(note_out), 32'd0);
    chk("rst_nv", 32'(note_valid), 32'd0);
    chk("rst_len", 32'(length), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(play_done), 32'd0);
    resetn = 1'b1;
    cyc();

    // Five notes, ticks separated by idle cycles.
    rec_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    record_seq(1'b0);
    chk("t2_len", 32'(length), 32'd5);
    start_play(1'b0);
    chk("t2_play_busy", 32'(busy), 32'd1);
    chk("t2_pre_nv", 32'(note_valid), 32'd0);
    play_check(5, 5, 1'b0, 1'b1);
    chk("t2_done_pulse", 32'(play_done), 32'd0);

    // rec_stop with a write in the same cycle keeps the write.
    rec_q = '{8'h21, 8'h22, 8'hAA};
    record_seq(1'b1);
    chk("t4_len", 32'(length), 32'd3);
    start_play(1'b0);
    play_check(3, 3, 1'b0, 1'b0);

    // Overflow: 34 words into 32 slots.
    rec_q.delete();
    for (int i = 0; i < 34; i++) rec_q.push_back(8'(8'h40 + i));
    record_seq(1'b0);
    chk("t3_len", 32'(length), 32'd32);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    start_play(1'b0);
    play_check(32, 32, 1'b0, 1'b0);

    // Empty sequence playback and rec/play priority.
    held = note_out;
    rec_q.delete();
    record_seq(1'b0);
    chk("t6_len0", 32'(length), 32'd0);
    chk("t6_full0", 32'(full), 32'd0);
    start_play(1'b0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(play_done), 32'd1);
    chk("t6_nv", 32'(note_valid), 32'd0);
    chk("t6_hold", 32'(note_out), 32'(held));
    cyc();
    chk("t6_done_end", 32'(play_done), 32'd0);
    rec_start = 1'b1; play_start = 1'b1;
    cyc();
    rec_start = 1'b0; play_start = 1'b0;
    chk("t6_both_busy", 32'(busy), 32'd1);
    chk("t6_both_nodone", 32'(play_done), 32'd0);
    rec_valid = 1'b1; rec_data = 8'h55;
    cyc();
    rec_valid = 1'b0;
    chk("t6_both_rec_len", 32'(length), 32'd1);
    rec_stop = 1'b1;
    cyc();
    rec_stop = 1'b0;
    chk("t6_both_idle", 32'(busy), 32'd0);

    // Looping (or ignored loop) with A,B,C.
    rec_q = '{8'h31, 8'h32, 8'h33};
    record_seq(1'b0);
    start_play(1'b1);
`ifdef SEQ_RAM_LOOP_EN
    play_check(7, 3, 1'b1, 1'b0);
    play_stop = 1'b1;
    cyc();
    play_stop = 1'b0;
    chk("t5_stop_done", 32'(play_done), 32'd1);
    chk("t5_stop_busy", 32'(busy), 32'd0);
    chk("t5_stop_nv", 32'(note_valid), 32'd0);
    chk("t5_stop_hold", 32'(note_out), 32'h31);
`else
    play_check(3, 3, 1'b0, 1'b0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("t5_idle_tick_nv", 32'(note_valid), 32'd0);
    chk("t5_idle_tick_hold", 32'(note_out), 32'h33);
`endif

    // play_stop together with tick: stop wins.
    start_play(1'b0);
    play_check(1, 3, 1'b1, 1'b0);
    tick = 1'b1; play_stop = 1'b1;
    cyc();
    tick = 1'b0; play_stop = 1'b0;
    chk("stop_tick_nv", 32'(note_valid), 32'd0);
    chk("stop_tick_done", 32'(play_done), 32'd1);
    chk("stop_tick_busy", 32'(busy), 32'd0);
    chk("stop_tick_hold", 32'(note_out), 32'h31);

    // Asynchronous reset in the middle of playback.
    start_play(1'b0);
    play_check(2, 3, 1'b1, 1'b0);
    resetn = 1'b0;
    #1;
    chk("t1_note", 32'(note_out), 32'd0);
    chk("t1_nv", 32'(note_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_len", 32'(length), 32'd0);
    chk("t1_done", 32'(play_done), 32'd0);
    #2;
    resetn = 1'b1;
    cyc();
    chk("t1_post_len", 32'(length), 32'd0);
    chk("t1_post_busy", 32'(busy), 32'd0);
    chk("t1_post_done", 32'(play_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
